// File: rtl/pipeline_types.sv
// Shared pipeline types: the decoded-instruction record passed from decode to dispatch
// and the front-end widths that size the decoded instruction queue.
package pipeline_types;

    localparam int DECODER_WIDTH = 2;
    localparam int ISSUE_WIDTH   = 2;
    localparam int DQ_DEPTH      = 8;

    typedef struct packed {
        logic        inst_valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
    } id_dispatch_t;

endpackage

// File: rtl/dq_enq_compact.sv
// Packs the decoder's per-slot valids into contiguous write lanes so the queue
// always writes from lane 0 upward, and reports how many entries are being offered.
module dq_enq_compact
    import pipeline_types::*;
(
    input  logic [DECODER_WIDTH-1:0]               enq_valid,
    input  id_dispatch_t [DECODER_WIDTH-1:0]       enq_data,
    output id_dispatch_t [DECODER_WIDTH-1:0]       wr_data,
    output logic [1:0]                             enq_n
);

    always_comb begin
        wr_data    = enq_data;
        // A lone slot-1 entry slides down into lane 0.
        if (!enq_valid[0]) begin
            wr_data[0] = enq_data[1];
        end
        wr_data[0].inst_valid = 1'b1;
        wr_data[1].inst_valid = 1'b1;
        enq_n = {1'b0, enq_valid[0]} + {1'b0, enq_valid[1]};
    end

endmodule

// File: rtl/decoded_inst_queue.sv
// Decoded instruction queue: circular buffer between decode and dispatch, two writes
// and up to two in-order retires per cycle, outputs driven only from registered state.
module decoded_inst_queue
    import pipeline_types::*;
#(
    parameter int DEPTH = DQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               pause,
    input  logic [1:0]                         enq_valid,
    input  id_dispatch_t [DECODER_WIDTH-1:0]   enq_data,
    output logic                               enq_ready,
    output id_dispatch_t [DECODER_WIDTH-1:0]   deq_data,
    output logic [1:0]                         deq_ages,
    input  logic [1:0]                         issue_en,
    output logic [PTR_W:0]                     count
);

    localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1);

    logic [PTR_W:0]                    head;
    logic [PTR_W:0]                    tail;
    id_dispatch_t                      mem [DEPTH];
    id_dispatch_t [DECODER_WIDTH-1:0]  wr_data;
    logic [1:0]                        enq_n;
    logic [1:0]                        req_n;
    logic [1:0]                        deq_n;
    logic                              do_enq;
    logic [PTR_W-1:0]                  wr_idx0;
    logic [PTR_W-1:0]                  wr_idx1;
    logic [PTR_W-1:0]                  rd_idx0;
    logic [PTR_W-1:0]                  rd_idx1;
    id_dispatch_t                      rd0;
    id_dispatch_t                      rd1;

    dq_enq_compact u_enq_compact (
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .wr_data   (wr_data),
        .enq_n     (enq_n)
    );

    assign count     = tail - head;
    assign enq_ready = (count <= READY_MAX);
    assign do_enq    = enq_ready && (|enq_valid);

    assign wr_idx0 = tail[PTR_W-1:0];
    assign wr_idx1 = wr_idx0 + PTR_W'(1);
    assign rd_idx0 = head[PTR_W-1:0];
    assign rd_idx1 = rd_idx0 + PTR_W'(1);

    // Retiring slot 1 without slot 0 would reorder the stream, so that mask retires nothing.
    always_comb begin
        case (issue_en)
            2'b11:   req_n = 2'd2;
            2'b01:   req_n = 2'd1;
            default: req_n = 2'd0;
        endcase
    end

    always_comb begin
        deq_n = req_n;
        if (pause || (count == '0)) begin
            deq_n = 2'd0;
        end else if ((count == CNT_ONE) && (req_n == 2'd2)) begin
            deq_n = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + (PTR_W + 1)'(deq_n);
            if (do_enq) begin
                tail <= tail + (PTR_W + 1)'(enq_n);
            end
        end
    end

    // Storage is deliberately left out of reset and flush; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (!flush && do_enq) begin
            mem[wr_idx0] <= wr_data[0];
            if (enq_n == 2'd2) begin
                mem[wr_idx1] <= wr_data[1];
            end
        end
    end

    assign rd0 = mem[rd_idx0];
    assign rd1 = mem[rd_idx1];

    always_comb begin
        deq_data               = '0;
        deq_data[0]            = rd0;
        deq_data[1]            = rd1;
        deq_data[0].inst_valid = (count != '0) && rd0.inst_valid;
        deq_data[1].inst_valid = (count > CNT_ONE) && rd1.inst_valid;
        deq_ages               = (count != '0) ? 2'b01 : 2'b00;
    end

endmodule

// File: tb/tb_decoded_inst_queue.sv
// Directed bench for decoded_inst_queue: a PC-ordered scoreboard queue predicts the
// head entries, occupancy and ready flag after every clock edge.
module tb_decoded_inst_queue;
    import pipeline_types::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    logic                              clk;
    logic                              rst_n;
    logic                              flush;
    logic                              pause;
    logic [1:0]                        enq_valid;
    id_dispatch_t [DECODER_WIDTH-1:0]  enq_data;
    logic                              enq_ready;
    id_dispatch_t [DECODER_WIDTH-1:0]  deq_data;
    logic [1:0]                        deq_ages;
    logic [1:0]                        issue_en;
    logic [PTR_W:0]                    count;

    int          compared   = 0;
    int          mismatched = 0;
    int          illegal_masks = 0;
    string       phase = "init";
    logic [31:0] exp_q[$];

    decoded_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .pause     (pause),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_data  (deq_data),
        .deq_ages  (deq_ages),
        .issue_en  (issue_en),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic id_dispatch_t mk(input logic [31:0] pc, input logic vld);
        id_dispatch_t e;
        e.inst_valid = vld;
        e.pc         = pc;
        e.opcode     = pc[8:2];
        e.rd         = pc[6:2] ^ 5'h15;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = exp_q.size();
        chk("count", 64'(count), 64'(sz));
        chk("enq_ready", 64'(enq_ready), 64'(sz <= DEPTH - 2));
        chk("deq_ages", 64'(deq_ages), (sz > 0) ? 64'd1 : 64'd0);
        chk("valid0", 64'(deq_data[0].inst_valid), 64'(sz > 0));
        chk("valid1", 64'(deq_data[1].inst_valid), 64'(sz > 1));
        if (sz > 0) chk("slot0", 64'(deq_data[0]), 64'(mk(exp_q[0], 1'b1)));
        if (sz > 1) chk("slot1", 64'(deq_data[1]), 64'(mk(exp_q[1], 1'b1)));
    endtask

    // Drive one cycle, update the scoreboard from pre-edge state, then check after the edge.
    task automatic step(input logic fl, input logic pa, input logic [1:0] ev,
                        input logic [31:0] pc0, input logic [31:0] pc1, input logic [1:0] ie);
        int n;
        int sz;
        flush       = fl;
        pause       = pa;
        enq_valid   = ev;
        enq_data[0] = mk(pc0, 1'b0);
        enq_data[1] = mk(pc1, 1'b0);
        issue_en    = ie;
        if (ie == 2'b10) begin
            illegal_masks++;
            $display("note: out-of-order issue mask 2'b10 at %0t, expected to be ignored", $time);
        end
        sz = exp_q.size();
        n  = (ie == 2'b11) ? 2 : (ie == 2'b01) ? 1 : 0;
        if (pa) n = 0;
        if (n > sz) n = sz;
        if (fl) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < n; i++) void'(exp_q.pop_front());
            if (sz <= DEPTH - 2) begin
                if (ev[0]) exp_q.push_back(pc0);
                if (ev[1]) exp_q.push_back(pc1);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic [1:0] ie);
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, ie);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        pause = 1'b0;
        enq_valid = 2'b00;
        enq_data = '0;
        issue_en = 2'b00;

        phase = "reset";
        #3;
        check_outputs();
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        phase = "reset_mid_fill";
        step(1'b0, 1'b0, 2'b11, 32'h100, 32'h104, 2'b00);
        step(1'b0, 1'b0, 2'b01, 32'h108, 32'h10c, 2'b00);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_outputs();
        #1 rst_n = 1'b1;

        phase = "ordering";
        step(1'b0, 1'b0, 2'b11, 32'h200, 32'h204, 2'b00);
        step(1'b0, 1'b0, 2'b10, 32'h2f0, 32'h208, 2'b00);
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
        idle(2'b11);
        idle(2'b11);

        phase = "full_7";
        step(1'b0, 1'b0, 2'b01, 32'h300, 32'h3f0, 2'b00);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 2'b11, 32'h304 + 8 * i, 32'h308 + 8 * i, 2'b00);
        step(1'b0, 1'b0, 2'b11, 32'hdead0, 32'hdead4, 2'b00);
        for (int i = 0; i < 4; i++) idle(2'b11);

        phase = "full_8";
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 2'b11, 32'h400 + 8 * i, 32'h404 + 8 * i, 2'b00);
        step(1'b0, 1'b0, 2'b11, 32'hbeef0, 32'hbeef4, 2'b00);
        step(1'b0, 1'b0, 2'b01, 32'hbeef8, 32'hbeefc, 2'b00);
        for (int i = 0; i < 4; i++) idle(2'b11);

        phase = "steady_wrap";
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 2'b11, 32'h500 + 8 * i, 32'h504 + 8 * i, 2'b00);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 2'b11, 32'h600 + 8 * i, 32'h604 + 8 * i, 2'b11);
        for (int i = 0; i < 3; i++) idle(2'b11);

        phase = "pause_illegal";
        step(1'b0, 1'b0, 2'b11, 32'h700, 32'h704, 2'b00);
        step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b11);
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b10);
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
        idle(2'b11);

        phase = "flush";
        step(1'b0, 1'b0, 2'b11, 32'h800, 32'h804, 2'b00);
        step(1'b0, 1'b0, 2'b11, 32'h808, 32'h80c, 2'b00);
        step(1'b0, 1'b0, 2'b01, 32'h810, 32'h814, 2'b00);
        step(1'b1, 1'b1, 2'b11, 32'h818, 32'h81c, 2'b11);
        step(1'b0, 1'b0, 2'b11, 32'h900, 32'h904, 2'b00);
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
        idle(2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
